// File: rtl/keypad_pkg.sv
// Shared types and tables for the matrix keypad scanner:
// debounce states, column drive patterns and the key map.
package keypad_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DEB_PRESS,
      PRESSED,
      DEB_REL
   } kp_state_e;

   localparam logic [3:0] COL0 = 4'b0111;
   localparam logic [3:0] COL1 = 4'b1011;
   localparam logic [3:0] COL2 = 4'b1101;
   localparam logic [3:0] COL3 = 4'b1110;

   function automatic logic [3:0] col_drive(input logic [1:0] c);
      logic [3:0] d;
      unique case (c)
         2'd0: d = COL0;
         2'd1: d = COL1;
         2'd2: d = COL2;
         2'd3: d = COL3;
      endcase
      return d;
   endfunction

   // idx = column*4 + row
   function automatic logic [4:0] key_map(input logic [3:0] idx);
      logic [4:0] k;
      unique case (idx)
         4'd0:  k = 5'h01;
         4'd1:  k = 5'h04;
         4'd2:  k = 5'h07;
         4'd3:  k = 5'h00;
         4'd4:  k = 5'h02;
         4'd5:  k = 5'h05;
         4'd6:  k = 5'h08;
         4'd7:  k = 5'h0F;
         4'd8:  k = 5'h03;
         4'd9:  k = 5'h06;
         4'd10: k = 5'h09;
         4'd11: k = 5'h0E;
         4'd12: k = 5'h0A;
         4'd13: k = 5'h0B;
         4'd14: k = 5'h0C;
         4'd15: k = 5'h0D;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-scan debounce FSM: accepts a single key after N matching
// scans and a release after N empty scans.
module keypad_debounce
   import keypad_pkg::*;
#(
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scan_end,
   input  logic       is_empty,
   input  logic       is_single,
   input  logic [4:0] key,
   output logic [4:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int NW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [NW-1:0] N_LAST = NW'(DEBOUNCE_SCANS - 1);
   localparam logic [NW-1:0] N_ONE  = NW'(1);

   kp_state_e     state_q;
   logic [NW-1:0] n_q;
   logic [4:0]    cand_q;
   logic [4:0]    code_q;
   logic          valid_q;
   logic          held_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         n_q     <= '0;
         cand_q  <= '0;
         code_q  <= '0;
         valid_q <= 1'b0;
         held_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (scan_end) begin
            unique case (state_q)
               IDLE: begin
                  if (is_single) begin
                     cand_q <= key;
                     n_q    <= N_ONE;
                     if (N_LAST == '0) begin
                        state_q <= PRESSED;
                        code_q  <= key;
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                     end else begin
                        state_q <= DEB_PRESS;
                     end
                  end
               end
               DEB_PRESS: begin
                  if (is_single && key == cand_q) begin
                     if (n_q == N_LAST) begin
                        state_q <= PRESSED;
                        code_q  <= cand_q;
                        valid_q <= 1'b1;
                        held_q  <= 1'b1;
                     end else begin
                        n_q <= n_q + N_ONE;
                     end
                  end else if (is_single) begin
                     cand_q <= key;
                     n_q    <= N_ONE;
                  end else begin
                     state_q <= IDLE;
                  end
               end
               PRESSED: begin
                  // ghosts and other keys are ignored: no rollover
                  if (is_empty) begin
                     n_q <= N_ONE;
                     if (N_LAST == '0) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                     end else begin
                        state_q <= DEB_REL;
                     end
                  end
               end
               DEB_REL: begin
                  if (is_empty) begin
                     if (n_q == N_LAST) begin
                        state_q <= IDLE;
                        held_q  <= 1'b0;
                     end else begin
                        n_q <= n_q + N_ONE;
                     end
                  end else begin
                     state_q <= PRESSED;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign key_held  = held_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column sequencer, row synchronizer,
// scan map and single-key encoder feeding the debounce FSM.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [4:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    c_q, c_d;
   logic [3:0]    sync1_q, sync2_q;
   logic [15:0]   map_q, map_d;
   logic [3:0]    row_s;
   logic          sample;
   logic          scan_end;
   logic          is_empty;
   logic          is_single;
   logic [3:0]    key_idx;

   always_comb begin
      row_s    = ~sync2_q;
      sample   = (cnt_q == CNT_LAST);
      scan_end = sample && (c_q == 2'd3);
      cnt_d    = sample ? '0 : cnt_q + CW'(1);
      c_d      = sample ? c_q + 2'd1 : c_q;
      map_d    = map_q;
      if (sample) map_d[{c_q, 2'b00} +: 4] = row_s;
      // evaluate with the column-3 nibble captured this cycle
      is_empty  = (map_d == '0);
      is_single = $onehot(map_d);
      key_idx   = '0;
      for (int i = 0; i < 16; i++) begin
         if (map_d[i]) key_idx = 4'(i);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q   <= '0;
         c_q     <= '0;
         sync1_q <= 4'hF;
         sync2_q <= 4'hF;
         map_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         c_q     <= c_d;
         sync1_q <= row;
         sync2_q <= sync1_q;
         map_q   <= map_d;
      end
   end

   assign col = col_drive(c_q);

   keypad_debounce #(
      .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
   ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .scan_end (scan_end),
      .is_empty (is_empty),
      .is_single(is_single),
      .key      (key_map(key_idx)),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad model that
// drives rows from the column drive and a pressed-key mask.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  row;
   logic [3:0]  col;
   logic [4:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] mask;

   int applied = 0;
   int miscompares = 0;
   int cyc = 0;

   keypad_scanner #(
      .SCAN_DIV(4),
      .DEBOUNCE_SCANS(3)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .row      (row),
      .col      (col),
      .key_code (key_code),
      .key_valid(key_valid),
      .key_held (key_held)
   );

   always #5 clk = ~clk;

   // column c is active when col[3-c] is low; mask bit = c*4 + r
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (mask[c*4+r] && !col[3-c]) row[r] = 1'b0;
         end
      end
   end

   typedef struct {
      logic [15:0] mask;
      int          scans;
      int          pulses;
      logic [4:0]  code;
      logic        held;
      logic        chk_col;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input int act, input int exp);
      applied++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_scans(input int n, input bit chk_col,
                            output int pulses);
      int col_bad;
      logic [3:0] ec;
      pulses  = 0;
      col_bad = 0;
      repeat (n * 16) begin
         @(posedge clk);
         cyc++;
         #1;
         if (key_valid) pulses++;
         ec = 4'b1000 >> ((cyc / 4) % 4);
         if (col != ~ec) col_bad++;
      end
      if (chk_col) check("col_sequence_errors", col_bad, 0);
   endtask

   initial begin
      int p;
      vecs[0]  = '{16'h0000, 2, 0, 5'h00, 1'b0, 1'b1};
      vecs[1]  = '{16'h0020, 2, 0, 5'h00, 1'b0, 1'b0};
      vecs[2]  = '{16'h0020, 1, 1, 5'h05, 1'b1, 1'b0};
      vecs[3]  = '{16'h0020, 2, 0, 5'h05, 1'b1, 1'b0};
      vecs[4]  = '{16'h0000, 2, 0, 5'h05, 1'b1, 1'b0};
      vecs[5]  = '{16'h0000, 1, 0, 5'h05, 1'b0, 1'b0};
      vecs[6]  = '{16'h0400, 2, 0, 5'h05, 1'b0, 1'b0};
      vecs[7]  = '{16'h0000, 1, 0, 5'h05, 1'b0, 1'b0};
      vecs[8]  = '{16'h0400, 2, 0, 5'h05, 1'b0, 1'b0};
      vecs[9]  = '{16'h0400, 1, 1, 5'h09, 1'b1, 1'b0};
      vecs[10] = '{16'h0000, 3, 0, 5'h09, 1'b0, 1'b0};
      vecs[11] = '{16'h9000, 6, 0, 5'h09, 1'b0, 1'b0};
      vecs[12] = '{16'h1000, 2, 0, 5'h09, 1'b0, 1'b0};
      vecs[13] = '{16'h1000, 1, 1, 5'h0A, 1'b1, 1'b0};
      vecs[14] = '{16'h0000, 3, 0, 5'h0A, 1'b0, 1'b0};
      vecs[15] = '{16'h0001, 3, 1, 5'h01, 1'b1, 1'b0};
      vecs[16] = '{16'h0011, 2, 0, 5'h01, 1'b1, 1'b0};
      vecs[17] = '{16'h0010, 4, 0, 5'h01, 1'b1, 1'b0};
      vecs[18] = '{16'h0000, 3, 0, 5'h01, 1'b0, 1'b0};

      mask  = 16'h0000;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_col", int'(col), int'(4'b0111));
      check("reset_code", int'(key_code), 0);
      check("reset_valid", int'(key_valid), 0);
      check("reset_held", int'(key_held), 0);
      reset = 1'b0;
      cyc   = 0;

      for (int i = 0; i < 19; i++) begin
         mask = vecs[i].mask;
         run_scans(vecs[i].scans, vecs[i].chk_col, p);
         check($sformatf("v%0d_pulses", i), p, vecs[i].pulses);
         check($sformatf("v%0d_code", i), int'(key_code),
               int'(vecs[i].code));
         check($sformatf("v%0d_held", i), int'(key_held),
               int'(vecs[i].held));
      end

      // reset in the middle of debouncing '0'
      mask = 16'h0008;
      run_scans(1, 1'b0, p);
      check("rst_pre_pulses", p, 0);
      repeat (8) begin
         @(posedge clk);
         cyc++;
      end
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_col", int'(col), int'(4'b0111));
      check("midrst_code", int'(key_code), 0);
      check("midrst_valid", int'(key_valid), 0);
      check("midrst_held", int'(key_held), 0);
      reset = 1'b0;
      cyc   = 0;
      run_scans(2, 1'b1, p);
      check("rst_two_scans_pulses", p, 0);
      run_scans(1, 1'b0, p);
      check("rst_third_scan_pulses", p, 1);
      check("rst_final_code", int'(key_code), 0);
      check("rst_final_held", int'(key_held), 1);

      $display("== %0d vectors applied, %0d miscompares ==",
               applied, miscompares);
      $finish;
   end

endmodule
